// File: rtl/toy_dog_core.sv
// Toy-dog controller core: button debounce, speed selection, speed-scaled step tick,
// wrapping activity counter and a multiplexed active-low 7-segment display.
module toy_dog_core #(
    parameter int NUM_SPEEDS  = 4,
    parameter int NUM_ACTS    = 8,
    parameter int BASE_PERIOD = 2**23,
    parameter int DEB_CYCLES  = 2**16,
    parameter int SCAN_PERIOD = 2**16,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          on_off,
    input  logic                          but_speed,
    input  logic                          act_clr,
    output logic [$clog2(NUM_SPEEDS)-1:0] speed,
    output logic [$clog2(NUM_ACTS)-1:0]   act,
    output logic                          tick,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [7:0]                    seg
);

    localparam int SW  = $clog2(NUM_SPEEDS);
    localparam int AW  = $clog2(NUM_ACTS);
    localparam int DW  = $clog2(DEB_CYCLES + 1);
    localparam int SCW = $clog2(SCAN_PERIOD + 1);
    localparam int DIW = $clog2(NUM_DIGITS);

    // Slowest period (speed 1); faster speeds are right shifts of it.
    localparam logic [63:0] P1  = 64'(BASE_PERIOD) << (NUM_SPEEDS - 2);
    localparam int          PW  = $clog2(P1);
    localparam logic [PW:0] P1_V = (PW+1)'(P1);

    logic           sync1, sync2, deb, deb_d, press;
    logic [DW-1:0]  deb_cnt;
    logic [PW-1:0]  pre;
    logic [PW:0]    period;
    logic [PW-1:0]  last;
    logic           running;
    logic           speed_step;
    logic [SCW-1:0] scan_cnt;
    logic [DIW-1:0] idx;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        period     = P1_V >> (speed - SW'(1));
        last       = PW'(period - (PW+1)'(1));
        running    = on_off && (speed != '0);
        speed_step = press && on_off;
        tick       = running && (pre == last) && !act_clr && !rst;
    end

    // Debounced level flips after DEB_CYCLES consecutive disagreeing samples;
    // the press pulse is registered off the 1->0 transition of that level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_d   <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= but_speed;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            if (sync2 != deb) begin
                if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    deb     <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Speed, activity and prescaler; the prescaler idles at zero whenever not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed <= '0;
            act   <= '0;
            pre   <= '0;
        end else begin
            if (speed_step)
                speed <= (speed == SW'(NUM_SPEEDS - 1)) ? '0 : speed + SW'(1);
            if (act_clr)
                act <= '0;
            else if (tick)
                act <= (act == AW'(NUM_ACTS - 1)) ? '0 : act + AW'(1);
            if (act_clr || speed_step || !running || (pre == last))
                pre <= '0;
            else
                pre <= pre + PW'(1);
        end
    end

    // Digit select and segments are registered together from the current scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            digit_en <= '1;
            seg      <= 8'hFF;
        end else begin
            if (scan_cnt == SCW'(SCAN_PERIOD - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == DIW'(NUM_DIGITS - 1)) ? '0 : idx + DIW'(1);
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end
            if (on_off) begin
                digit_en <= ~(NUM_DIGITS'(1) << idx);
                if (idx == DIW'(0))
                    seg <= hex7(4'(act));
                else if (idx == DIW'(1))
                    seg <= hex7(4'(speed));
                else
                    seg <= 8'hFF;
            end else begin
                digit_en <= '1;
                seg      <= 8'hFF;
            end
        end
    end

endmodule

// File: doc/toy_dog_core.md
# toy_dog_core

Single-clock core of the toy-dog controller: debounces the speed button, cycles through a parametrised number of speeds, generates a speed-dependent step tick with an internal prescaler, and advances a wrapping activity counter on each tick. It also drives a multiplexed, active-low 7-segment display showing activity and speed. It is the parametrised successor to the gated-clock, fixed 4-speed/8-activity top: no derived clocks, only clock enables.

## Interface
Parameters:
- NUM_SPEEDS, 4, number of speed settings including 0 (stopped); ≥2, ≤16
- NUM_ACTS, 8, number of activities; ≥2, ≤16
- BASE_PERIOD, 2^23, tick period in cycles at the fastest speed; ≥2
- DEB_CYCLES, 2^16, consecutive stable cycles needed to accept a button level; ≥1
- SCAN_PERIOD, 2^16, cycles each digit stays selected; ≥1
- NUM_DIGITS, 4, display digits; ≥2

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- on_off  in  1  1 = run, 0 = paused and display blanked
- but_speed  in  1  raw speed button, active-low, asynchronous
- act_clr  in  1  synchronous active-high clear of activity counter and prescaler
- speed  out  SW=$clog2(NUM_SPEEDS)  current speed index
- act  out  AW=$clog2(NUM_ACTS)  current activity index
- tick  out  1  one-cycle step pulse
- digit_en  out  NUM_DIGITS  active-low one-hot digit select
- seg  out  8  active-low segments {P,G,F,E,D,C,B,A}

## Operation
- Reset: speed=0, act=0, tick=0, prescaler=0, scan index=0, scan counter=0, debounced level=1 (released), synchronizer flops=1, digit_en all 1, seg all 1.
- Synchronizer: but_speed passes through two flops before use.
- Debouncer: a counter increments while the synchronized level differs from the debounced level and clears otherwise. When it reaches DEB_CYCLES, the debounced level takes the new value and the counter clears. A 1→0 debounced transition raises a registered one-cycle press pulse. Release generates nothing. The debouncer runs regardless of on_off.
- Speed FSM (states 0..NUM_SPEEDS-1): press with on_off=1 makes speed = speed+1, wrapping NUM_SPEEDS-1→0. Press with on_off=0 is dropped, not queued. Any speed change clears the prescaler.
- Prescaler: period P(s) = BASE_PERIOD << (NUM_SPEEDS-1-s) for s≥1. It counts only when on_off=1 and speed≠0. At count P(s)-1 it asserts tick for one cycle and returns to 0. With speed=0 or on_off=0 it holds at 0 and tick=0. Width must hold P(1)-1.
- Activity: act increments on each tick, wrapping NUM_ACTS-1→0.
- act_clr: sets act=0 and prescaler=0, and suppresses tick that cycle.
- Priority: rst > act_clr > press/tick. A press and a tick in the same cycle both take effect: act increments, speed changes, and the prescaler clears.
- on_off=0: speed, act and prescaler hold; digit_en=all 1; seg=all 1. The scan counter keeps running.
- Display: the scan counter counts 0..SCAN_PERIOD-1, then the digit index advances and wraps after NUM_DIGITS-1.
  - Digit 0 shows act as hex and digit 1 shows speed as hex, using standard hex patterns with DP off.
  - Other digits are blank (seg=all 1) and remain selected in rotation.
  - digit_en and seg are registered together, so they never mismatch.

## Timing
- Button: raw falling edge sampled at edge k. The press pulse is high after edge k+DEB_CYCLES+2, and speed updates at edge k+DEB_CYCLES+3.
- Glitch: a raw low shorter than DEB_CYCLES cycles produces no press.
- Tick: after a speed change, act_clr or on_off rising, the first tick is high in cycle P(s)-1 counted from the clear. After that, ticks come exactly every P(s) cycles. act reflects a tick one cycle later.
- Display: each digit is enabled for exactly SCAN_PERIOD cycles. The digit_en/seg pair updates one cycle after the scan index changes.
- Mid-operation rst: all registers return to reset values on the next edge. No press or tick is emitted from pre-reset state.

## Test plan
All scenarios use NUM_SPEEDS=4, NUM_ACTS=8, BASE_PERIOD=4, DEB_CYCLES=3, SCAN_PERIOD=2, NUM_DIGITS=4.
- Reset then idle 100 cycles -> speed=0, act=0, tick never high, digit_en cycles 1110,1101,1011,0111 every 2 cycles, digit0 seg=0xC0 ("0").
- Four clean presses -> speed 1,2,3,0. Tick periods are 16, 8 and 4 cycles, and no tick at speed 0. act wraps 7→0 after 8 ticks.
- Press with raw bounce of 2-cycle lows, then a stable low -> exactly one speed increment, DEB_CYCLES+3 edges after the stable low begins.
- act_clr asserted in the same cycle as tick at speed 3 -> act=0, no increment, next tick 4 cycles after the clear.
- on_off=0 at speed 2 with a press during the pause -> speed and act frozen, display all 1s, press discarded. on_off=1 -> first tick after 8 cycles.
- rst asserted mid-count at speed 3, act=5 -> next cycle all outputs at reset values, and no tick for the following 10 cycles.
